shared_adder_arbiter: RTL

Shares one WIDTH-bit adder datapath between NUM_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter grants one pair per cycle into a two-stage pipeline: an operand register, then a result register. The result leaves on a single response channel tagged with the requester ID. The block sits between the per-channel operand producers and the sum consumer, and replaces per-channel adder instances.

---
 rtl/shared_adder_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter feeding one shared WIDTH-bit adder through a
// two-stage pipeline (operand register, result register) with tagged output.
module shared_adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     IN_clk,
  input  logic                     IN_rst_n,
  input  logic [NUM_REQ-1:0]       IN_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] IN_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] IN_req_b,
  output logic [NUM_REQ-1:0]       OUT_req_ready,
  output logic                     OUT_rsp_valid,
  input  logic                     IN_rsp_ready,
  output logic [ID_W-1:0]          OUT_rsp_id,
  output logic [WIDTH-1:0]         OUT_rsp_sum,
  output logic                     OUT_rsp_carry
);

  logic [ID_W-1:0]    r_ptr;
  logic               r_v1;
  logic [ID_W-1:0]    r_id1;
  logic [WIDTH-1:0]   r_a1;
  logic [WIDTH-1:0]   r_b1;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_found;
  logic [ID_W:0]        w_pos;
  logic [ID_W-1:0]      w_gid;
  logic [ID_W-1:0]      w_nxt;
  logic                 w_s2_free;
  logic                 w_s1_free;
  logic                 w_acc;
  logic                 w_adv;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [WIDTH:0]       w_sum;

  assign w_s2_free = !OUT_rsp_valid || IN_rsp_ready;
  assign w_s1_free = !r_v1 || w_s2_free;
  assign w_adv     = r_v1 && w_s2_free;

  // Rotate valids so bit 0 is the pointer slot; lowest rotated hit wins.
  always_comb begin
    w_dbl   = {IN_req_valid, IN_req_valid} >> r_ptr;
    w_rot   = w_dbl[NUM_REQ-1:0];
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_pos   = {1'b0, r_ptr} + (ID_W+1)'(k);
      end
    end
    if (w_pos >= (ID_W+1)'(NUM_REQ))
      w_pos = w_pos - (ID_W+1)'(NUM_REQ);
    w_gid = w_pos[ID_W-1:0];
    if (w_gid == ID_W'(NUM_REQ - 1))
      w_nxt = '0;
    else
      w_nxt = w_gid + ID_W'(1);
  end

  assign w_acc = IN_rst_n && w_s1_free && w_found;

  always_comb begin
    w_gnt = '0;
    w_a   = '0;
    w_b   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt[k] = w_acc && (w_gid == ID_W'(k));
      if (w_gnt[k]) begin
        w_a = IN_req_a[k*WIDTH +: WIDTH];
        w_b = IN_req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign OUT_req_ready = w_gnt;
  assign w_sum = {1'b0, r_a1} + {1'b0, r_b1};

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      r_ptr         <= '0;
      r_v1          <= 1'b0;
      r_id1         <= '0;
      r_a1          <= '0;
      r_b1          <= '0;
      OUT_rsp_valid <= 1'b0;
      OUT_rsp_id    <= '0;
      OUT_rsp_sum   <= '0;
      OUT_rsp_carry <= 1'b0;
    end else begin
      if (w_acc) begin
        r_v1  <= 1'b1;
        r_id1 <= w_gid;
        r_a1  <= w_a;
        r_b1  <= w_b;
        r_ptr <= w_nxt;
      end else if (w_adv) begin
        r_v1 <= 1'b0;
      end
      if (w_adv) begin
        OUT_rsp_valid <= 1'b1;
        OUT_rsp_id    <= r_id1;
        {OUT_rsp_carry, OUT_rsp_sum} <= w_sum;
      end else if (OUT_rsp_valid && IN_rsp_ready) begin
        OUT_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
